mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 rdy  in  1  global enable; low = freeze all state.
REQ-004 if_req / if_addr  in  1/32  instruction-fetch read request (always 4 bytes), held until if_done.
REQ-005 if_done / if_data  out  1/32  one-cycle completion pulse; little-endian word valid with pulse.
REQ-006 ls_req / ls_wr / ls_size / ls_addr / ls_wdata  in  1/1/2/32/32  load-store request; ls_size 0=1B, 1=2B, 2=4B; held until ls_done.
REQ-007 ls_done / ls_rdata  out  1/32  one-cycle completion pulse; read data zero-extended, valid with pulse.
REQ-008 jump_wrong  in  1  misprediction flush.
REQ-009 mem_din  in  8  RAM read byte, valid one cycle after its address.
REQ-010 mem_dout / mem_a / mem_wr  out  8/32/1  RAM write byte, byte address, write strobe.
REQ-011 io_buffer_full  in  1  UART buffer full; stalls writes to IO space (addr[17:16]==2'b11).

Function
REQ-012 SHALL implement states IDLE, IF_READ, LS_READ, LS_WRITE with a byte counter cnt (0..5).
REQ-013 In IDLE with both requests pending, SHALL grant round-robin via last_grant bit: the requester not granted last wins; a single pending request is granted directly.
REQ-014 SHALL NOT grant a requester in the cycle its own done pulse is high.
REQ-015 Grant at edge T SHALL latch address, size (N=1/2/4) and write data, and set cnt=0.
REQ-016 Read: mem_a = base+k, mem_wr=0 during cycle after edge T+k, k=0..N-1; byte k sampled at edge T+k+2 into bits [8k+7:8k].
REQ-017 Read done SHALL pulse in the cycle after edge T+N+1 (4-byte fetch: after T+5); state returns to IDLE at that edge.
REQ-018 Write: mem_a = base+k, mem_dout = wdata[8k+7:8k], mem_wr=1 during cycle after edge T+k; ls_done pulses in cycle after edge T+N.
REQ-019 IO write stall: if target addr[17:16]==2'b11 and io_buffer_full=1, SHALL drive mem_wr=0 and not advance cnt that cycle; resumes when clear.
REQ-020 In IDLE, or when no byte is driven, SHALL output mem_a=0, mem_wr=0, mem_dout=0.
REQ-021 jump_wrong in IF_READ or LS_READ SHALL abort to IDLE at that edge, no done pulse, no data update; cnt cleared.
REQ-022 jump_wrong in LS_WRITE SHALL be ignored; write completes and ls_done pulses.
REQ-023 jump_wrong in IDLE SHALL suppress any grant that edge.
REQ-024 rdy=0 SHALL hold state, cnt, data registers, and force mem_wr=0; done pulses not issued while rdy=0.
REQ-025 Unused upper bytes of ls_rdata SHALL be zero; ls_size=3 treated as 4 bytes.

Reset
REQ-026 rst at any edge (including mid-transfer) SHALL force IDLE, cnt=0, last_grant=LS (so IF wins first tie), if_done=0, ls_done=0, if_data=0, ls_rdata=0, mem_wr=0, mem_a=0, mem_dout=0.
REQ-027 rst SHALL take priority over rdy and jump_wrong.

Verification
REQ-028 if_req, if_addr=0x100, RAM bytes 13,00,00,00 -> mem_a 0x100..0x103 on four cycles, if_done after edge T+5, if_data=0x00000013.
REQ-029 ls_req write, size 1, addr 0x200, wdata 0xAABBCCDD -> mem_wr=1 two cycles, bytes DD,CC at 0x200,0x201, ls_done after T+2.
REQ-030 if_req and ls_req same cycle after reset -> IF granted first, LS granted after if_done; repeat -> order alternates.
REQ-031 jump_wrong at edge T+3 of fetch -> IDLE, no if_done, mem_a=0 next cycle; same during 4-byte store -> all 4 bytes written, ls_done pulses.
REQ-032 byte write to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 those cycles, then one write, ls_done next cycle.
REQ-033 rst asserted mid-read -> all outputs zero next cycle, no done pulse; new request accepted normally afterwards.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction-fetch and load/store
// requests onto an 8-bit RAM port, with IO write back-pressure and flush abort.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_done_o,
  output logic [31:0] if_data_o,
  input  logic        ls_req_i,
  input  logic        ls_wr_i,
  input  logic [1:0]  ls_size_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_done_o,
  output logic [31:0] ls_rdata_o,
  input  logic        jump_wrong_i,
  input  logic [7:0]  mem_din_i,
  output logic [7:0]  mem_dout_o,
  output logic [31:0] mem_a_o,
  output logic        mem_wr_o,
  input  logic        io_buffer_full_i
);

  // state    | meaning
  // IDLE     | no transfer; arbitrate pending requests
  // IF_READ  | 4-byte instruction fetch in progress
  // LS_READ  | 1/2/4-byte load in progress
  // LS_WRITE | 1/2/4-byte store in progress
  typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_e;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_LS = 1'b1;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        if_done_q, if_done_d;
  logic        ls_done_q, ls_done_d;
  logic        last_grant_q, last_grant_d;

  logic [31:0] cur_addr;
  logic [1:0]  rd_idx;
  logic        io_stall;
  logic        if_pend;
  logic        ls_pend;
  logic        pick_ls;

  function automatic logic [2:0] size_len(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign cur_addr = base_q + {29'd0, cnt_q};
  assign rd_idx   = cnt_q[1:0] - 2'd1;
  assign io_stall = (cur_addr[17:16] == 2'b11) && io_buffer_full_i;
  assign if_pend  = if_req_i && !if_done_q;
  assign ls_pend  = ls_req_i && !ls_done_q;
  assign pick_ls  = ls_pend && (!if_pend || last_grant_q == GRANT_IF);

  assign if_done_o  = if_done_q && rdy_i;
  assign ls_done_o  = ls_done_q && rdy_i;
  assign if_data_o  = if_data_q;
  assign ls_rdata_o = ls_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      len_q        <= 3'd0;
      base_q       <= 32'd0;
      wdata_q      <= 32'd0;
      buf_q        <= 32'd0;
      if_data_q    <= 32'd0;
      ls_rdata_q   <= 32'd0;
      if_done_q    <= 1'b0;
      ls_done_q    <= 1'b0;
      last_grant_q <= GRANT_LS;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      buf_q        <= buf_d;
      if_data_q    <= if_data_d;
      ls_rdata_q   <= ls_rdata_d;
      if_done_q    <= if_done_d;
      ls_done_q    <= ls_done_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    if_data_d    = if_data_q;
    ls_rdata_d   = ls_rdata_q;
    if_done_d    = if_done_q;
    ls_done_d    = ls_done_q;
    last_grant_d = last_grant_q;
    mem_a_o      = 32'd0;
    mem_wr_o     = 1'b0;
    mem_dout_o   = 8'd0;

    if (rdy_i) begin
      if_done_d = 1'b0;
      ls_done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (!jump_wrong_i && (if_pend || ls_pend)) begin
            cnt_d        = 3'd0;
            buf_d        = 32'd0;
            last_grant_d = pick_ls ? GRANT_LS : GRANT_IF;
            if (pick_ls) begin
              base_d  = ls_addr_i;
              len_d   = size_len(ls_size_i);
              wdata_d = ls_wdata_i;
              state_d = ls_wr_i ? LS_WRITE : LS_READ;
            end else begin
              base_d  = if_addr_i;
              len_d   = 3'd4;
              state_d = IF_READ;
            end
          end
        end
        IF_READ, LS_READ: begin
          if (cnt_q < len_q) mem_a_o = cur_addr;
          if (jump_wrong_i) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
          end else begin
            // byte for the address issued one cycle earlier arrives now
            if (cnt_q != 3'd0) buf_d[{rd_idx, 3'b000} +: 8] = mem_din_i;
            if (cnt_q == len_q) begin
              state_d = IDLE;
              cnt_d   = 3'd0;
              if (state_q == IF_READ) begin
                if_data_d = buf_d;
                if_done_d = 1'b1;
              end else begin
                ls_rdata_d = buf_d;
                ls_done_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        LS_WRITE: begin
          if (!io_stall) begin
            mem_a_o    = cur_addr;
            mem_wr_o   = 1'b1;
            mem_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            if (cnt_q == len_q - 3'd1) begin
              state_d   = IDLE;
              cnt_d     = 3'd0;
              ls_done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else if ((state_q == IF_READ || state_q == LS_READ) && cnt_q != 3'd0) begin
      // while frozen, re-present the last issued address so the byte pending
      // for the next sampling edge is still the right one when rdy returns
      mem_a_o = cur_addr - 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed timing scenarios followed by
// randomized concurrent fetch/load/store traffic against a RAM + scoreboard model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        jump_wrong;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_full;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .rdy_i            (rdy),
    .if_req_i         (if_req),
    .if_addr_i        (if_addr),
    .if_done_o        (if_done),
    .if_data_o        (if_data),
    .ls_req_i         (ls_req),
    .ls_wr_i          (ls_wr),
    .ls_size_i        (ls_size),
    .ls_addr_i        (ls_addr),
    .ls_wdata_i       (ls_wdata),
    .ls_done_o        (ls_done),
    .ls_rdata_o       (ls_rdata),
    .jump_wrong_i     (jump_wrong),
    .mem_din_i        (mem_din),
    .mem_dout_o       (mem_dout),
    .mem_a_o          (mem_a),
    .mem_wr_o         (mem_wr),
    .io_buffer_full_i (io_full)
  );

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  ram [0:262143];
  logic [31:0] a_last = 32'd0;
  bit          chk_wr = 1'b0;
  bit          if_fin = 1'b0;
  bit          ls_fin = 1'b0;
  wr_t         exp_wr[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // RAM model: data for last cycle's address, writes applied and scoreboarded
  always @(negedge clk) begin : ram_model
    wr_t e;
    #2;
    mem_din = ram[a_last[17:0]];
    a_last  = mem_a;
    if (mem_wr) begin
      ram[mem_a[17:0]] = mem_dout;
      if (chk_wr) begin
        if (exp_wr.size() > 0) e = exp_wr.pop_front();
        else begin
          e.a = 32'hFFFF_FFFF;
          e.d = 8'h00;
        end
        check_val("wr_addr", mem_a, e.a);
        check_val("wr_data", {24'd0, mem_dout}, {24'd0, e.d});
        check_val("wr_rdy", {31'd0, rdy}, 32'd1);
        check_val("wr_io_stall", {31'd0, io_full && mem_a[17:16] == 2'b11}, 32'd0);
      end
    end
  end

  function automatic logic [31:0] ram_word(input logic [31:0] a, input int n);
    logic [31:0] w = 32'd0;
    logic [31:0] ad;
    for (int k = 0; k < n; k++) begin
      ad = a + k;
      w  = w | (32'(ram[ad[17:0]]) << (8 * k));
    end
    return w;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_mem_a"}, mem_a, 32'd0);
    check_val({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
    check_val({tag, "_mem_dout"}, {24'd0, mem_dout}, 32'd0);
    check_val({tag, "_if_done"}, {31'd0, if_done}, 32'd0);
    check_val({tag, "_ls_done"}, {31'd0, ls_done}, 32'd0);
    check_val({tag, "_if_data"}, if_data, 32'd0);
    check_val({tag, "_ls_rdata"}, ls_rdata, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0; io_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_done(input bit is_ls, input int budget, input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      step();
      seen = is_ls ? ls_done : if_done;
    end
    check_val(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic if_agent();
    logic [31:0] a;
    logic [31:0] expd;
    for (int t = 0; t < 40; t++) begin
      a       = 32'($urandom_range(0, 4092));
      expd    = ram_word(a, 4);
      if_addr = a;
      if_req  = 1'b1;
      wait_done(1'b0, 400, "rnd_if_done");
      check_val("rnd_if_data", if_data, expd);
      if_req = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    if_fin = 1'b1;
  endtask

  task automatic ls_agent();
    logic [31:0] a, wd, expd, ad;
    logic [1:0]  sz;
    bit          wr;
    int          n;
    for (int t = 0; t < 40; t++) begin
      sz = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      a  = ($urandom_range(0, 3) == 0) ? 32'h30000 + 32'($urandom_range(0, 255))
                                       : 32'h1000 + 32'($urandom_range(0, 4095));
      wd = $urandom;
      expd = ram_word(a, n);
      if (wr) begin
        for (int k = 0; k < n; k++) begin
          ad = a + k;
          exp_wr.push_back('{a: ad, d: wd[8*k +: 8]});
        end
      end
      ls_addr = a; ls_size = sz; ls_wr = wr; ls_wdata = wd; ls_req = 1'b1;
      wait_done(1'b1, 400, "rnd_ls_done");
      if (!wr) check_val("rnd_ls_rdata", ls_rdata, expd);
      ls_req = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
    ls_fin = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = 8'($urandom);
    ram[18'h100] = 8'h13; ram[18'h101] = 8'h00; ram[18'h102] = 8'h00; ram[18'h103] = 8'h00;
    ram[18'h240] = 8'h5A; ram[18'h241] = 8'hC3;

    // reset state
    do_reset();
    check_idle_outputs("rst");

    // 4-byte fetch timing, no regrant while done is high
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("fetch_mem_a", mem_a, 32'h100 + k);
      check_val("fetch_mem_wr", {31'd0, mem_wr}, 32'd0);
    end
    step();
    check_val("fetch_early_done", {31'd0, if_done}, 32'd0);
    check_val("fetch_gap_mem_a", mem_a, 32'd0);
    step();
    check_val("fetch_done", {31'd0, if_done}, 32'd1);
    check_val("fetch_data", if_data, 32'h0000_0013);
    step();
    check_val("fetch_done_pulse", {31'd0, if_done}, 32'd0);
    check_val("no_regrant_on_done", mem_a, 32'd0);
    if_req = 1'b0;
    step();

    // 2-byte store timing
    ls_addr = 32'h200; ls_size = 2'd1; ls_wr = 1'b1; ls_wdata = 32'hAABB_CCDD; ls_req = 1'b1;
    step();
    check_val("st_wr0", {31'd0, mem_wr}, 32'd1);
    check_val("st_a0", mem_a, 32'h200);
    check_val("st_d0", {24'd0, mem_dout}, 32'hDD);
    step();
    check_val("st_wr1", {31'd0, mem_wr}, 32'd1);
    check_val("st_a1", mem_a, 32'h201);
    check_val("st_d1", {24'd0, mem_dout}, 32'hCC);
    step();
    check_val("st_done", {31'd0, ls_done}, 32'd1);
    check_val("st_wr_end", {31'd0, mem_wr}, 32'd0);
    check_val("st_ram", {16'd0, ram[18'h201], ram[18'h200]}, 32'h0000_CCDD);
    ls_req = 1'b0;
    step();

    // round-robin arbitration
    do_reset();
    if_addr = 32'h100; ls_addr = 32'h240; ls_size = 2'd1; ls_wr = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    step();
    check_val("rr_first_if", mem_a, 32'h100);
    wait_done(1'b0, 20, "rr_if_done");
    check_val("rr_if_data", if_data, 32'h13);
    if_req = 1'b0;
    step();
    check_val("rr_then_ls", mem_a, 32'h240);
    wait_done(1'b1, 20, "rr_ls_done");
    check_val("rr_ls_rdata", ls_rdata, 32'h0000_C35A);
    ls_req = 1'b0;
    step();
    if_req = 1'b1; ls_req = 1'b1;
    step();
    check_val("rr_alt_if", mem_a, 32'h100);
    wait_done(1'b0, 20, "rr_if_done2");
    if_req = 1'b0;
    step();
    check_val("rr_alt_then_ls", mem_a, 32'h240);
    wait_done(1'b1, 20, "rr_ls_done2");
    ls_req = 1'b0;
    step();
    if_req = 1'b1;
    wait_done(1'b0, 20, "rr_if_alone");
    if_req = 1'b0;
    step();
    if_req = 1'b1; ls_req = 1'b1;
    step();
    check_val("rr_alt_ls", mem_a, 32'h240);
    wait_done(1'b1, 20, "rr_ls_done3");
    ls_req = 1'b0;
    step();
    check_val("rr_alt_then_if", mem_a, 32'h100);
    wait_done(1'b0, 20, "rr_if_done3");
    if_req = 1'b0;
    step();

    // flush aborts a fetch at edge T+3
    if_addr = 32'h104; if_req = 1'b1;
    step(); step(); step();
    jump_wrong = 1'b1; if_req = 1'b0;
    step();
    jump_wrong = 1'b0;
    check_val("jw_fetch_mem_a", mem_a, 32'd0);
    for (int c = 0; c < 4; c++) begin
      check_val("jw_fetch_no_done", {31'd0, if_done}, 32'd0);
      step();
    end
    check_val("jw_fetch_data_kept", if_data, 32'h13);

    // flush ignored during a 4-byte store
    ls_addr = 32'h300; ls_size = 2'd2; ls_wr = 1'b1; ls_wdata = 32'h1122_3344; ls_req = 1'b1;
    step(); step();
    jump_wrong = 1'b1;
    step();
    jump_wrong = 1'b0;
    step(); step();
    check_val("jw_store_done", {31'd0, ls_done}, 32'd1);
    check_val("jw_store_ram", {ram[18'h303], ram[18'h302], ram[18'h301], ram[18'h300]}, 32'h1122_3344);
    ls_req = 1'b0;
    step();

    // flush in IDLE suppresses the grant
    if_addr = 32'h100; if_req = 1'b1; jump_wrong = 1'b1;
    step();
    check_val("jw_idle_nogrant", mem_a, 32'd0);
    jump_wrong = 1'b0;
    step();
    check_val("jw_idle_then_grant", mem_a, 32'h100);
    wait_done(1'b0, 20, "jw_idle_done");
    if_req = 1'b0;
    step();

    // IO write stall for three cycles
    io_full = 1'b1;
    ls_addr = 32'h30000; ls_size = 2'd0; ls_wr = 1'b1; ls_wdata = 32'h0000_005E; ls_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check_val("io_stall_wr", {31'd0, mem_wr}, 32'd0);
    end
    @(posedge clk);
    #1;
    io_full = 1'b0;
    @(negedge clk);
    #1;
    check_val("io_wr", {31'd0, mem_wr}, 32'd1);
    check_val("io_a", mem_a, 32'h30000);
    check_val("io_d", {24'd0, mem_dout}, 32'h5E);
    step();
    check_val("io_done", {31'd0, ls_done}, 32'd1);
    ls_req = 1'b0;
    step();

    // rdy low for two edges delays a fetch by two cycles
    if_addr = 32'h100; if_req = 1'b1;
    step(); step();
    rdy = 1'b0;
    step(); step();
    rdy = 1'b1;
    step(); step(); step();
    check_val("rdy_no_early_done", {31'd0, if_done}, 32'd0);
    step();
    check_val("rdy_done", {31'd0, if_done}, 32'd1);
    check_val("rdy_data", if_data, 32'h13);
    if_req = 1'b0;
    step();

    // reset mid-read
    if_addr = 32'h100; if_req = 1'b1;
    step(); step(); step();
    rst = 1'b1;
    step();
    check_idle_outputs("rst_mid");
    rst = 1'b0; if_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check_val("rst_mid_no_done", {31'd0, if_done}, 32'd0);
    end
    if_req = 1'b1;
    wait_done(1'b0, 20, "rst_after_done");
    check_val("rst_after_data", if_data, 32'h13);
    if_req = 1'b0;
    step();

    // randomized concurrent traffic
    chk_wr = 1'b1;
    fork
      if_agent();
      ls_agent();
      begin
        while (!(if_fin && ls_fin)) begin
          @(negedge clk);
          rdy     = ($urandom_range(0, 3) != 0);
          io_full = ($urandom_range(0, 2) == 0);
        end
      end
    join
    rdy = 1'b1;
    io_full = 1'b0;
    repeat (5) step();
    check_val("rnd_wr_pending", 32'(exp_wr.size()), 32'd0);
    chk_wr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
